pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage, forwarding-equipped integer pipeline.
- Generates latch enables, flushes and bubbles for three cases: load-use hazards, decode-resolved branch/jr operand hazards, and taken-branch flushes.
- Owns the multicycle mult/div occupancy FSM that freezes the front end while the multdiv unit computes.
- Sits beside the bypass network. It covers exactly the cases forwarding cannot resolve.

Parameters:
MULT_LAT, 4, mult cycles from md_start to result valid (>=2)
DIV_LAT, 8, div cycles from md_start to result valid (>=2)
CNT_W, 32, width of stall-cycle performance counter

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-high
FD_rs  in  5  decode source A specifier
FD_rt  in  5  decode source B specifier (rd for branch/jr, already muxed)
FD_usesRs  in  1  decode instr reads FD_rs
FD_usesRt  in  1  decode instr reads FD_rt
FD_isCtrl  in  1  decode instr is a branch/jr resolved in D
D_branchTaken  in  1  branch/jr resolved taken in D
DX_rd  in  5  X-stage destination
DX_regWrite  in  1  X-stage instr writes a register
DX_memRead  in  1  X-stage instr is a load
DX_isMult  in  1  X-stage instr is mult
DX_isDiv  in  1  X-stage instr is div
XM_rd  in  5  M-stage destination
XM_memRead  in  1  M-stage instr is a load
X_branchTaken  in  1  branch resolved taken in X
pc_en  out  1  PC write enable
FD_en  out  1  F/D latch enable
DX_en  out  1  D/X latch enable
FD_flush  out  1  load nop into F/D
DX_flush  out  1  load nop into D/X
XM_bubble  out  1  load nop into X/M
md_start  out  1  one-cycle start pulse to multdiv unit
md_busy  out  1  multdiv occupancy in progress
md_done  out  1  multdiv result valid this cycle
stallCycles  out  CNT_W  count of cycles with pc_en=0

Behaviour:
- States: IDLE, BUSY, DONE. Registered state, down-counter md_cnt (width fits DIV_LAT) and stallCycles.
- reset=1: state=IDLE, md_cnt=0, stallCycles=0.
- reset=1: pc_en, FD_en, DX_en=0; all flush/bubble/md_* outputs=0.
- Default, no event: pc_en=FD_en=DX_en=1, flush/bubble=0.
- Priority, highest first: reset, MD occupancy, X_branchTaken, decode stall, D_branchTaken.
- MD start, state IDLE and (DX_isMult|DX_isDiv):
  - md_start=1, md_busy=1.
  - pc_en=FD_en=DX_en=0, XM_bubble=1.
  - md_cnt<=LAT-1, next state BUSY.
  - If both isMult and isDiv are set, DIV_LAT is used.
- BUSY:
  - md_busy=1, same freeze and bubble as the start cycle.
  - md_cnt decrements each cycle. When md_cnt==1, next state is DONE.
  - BUSY lasts LAT-1 cycles.
- DONE:
  - Lasts one cycle. md_done=1, md_busy=0, next state IDLE.
  - md_start is suppressed even though DX_isMult/isDiv is still high.
  - All other logic is evaluated normally.
  - Total D/X residency of a mult/div instr is LAT+1 cycles.
- X_branchTaken in any MD-occupancy cycle (start or BUSY) is ignored. It is illegal; the bench asserts it never occurs.
- Load-use stall condition:
  - DX_memRead, DX_rd!=0, and (FD_usesRs & FD_rs==DX_rd or FD_usesRt & FD_rt==DX_rd).
- Decode-ctrl stall condition: FD_isCtrl, and a used source matches one of:
  - DX_rd!=0 with DX_regWrite.
  - XM_rd!=0 with XM_memRead.
- Decode stall (either condition): pc_en=FD_en=0, DX_flush=1, DX_en=1.
- X_branchTaken (no MD occupancy):
  - FD_flush=DX_flush=1, enables=1.
  - Any decode stall and D_branchTaken are suppressed, since that instr is being killed.
- D_branchTaken with no decode stall and no X flush: FD_flush=1.
- D_branchTaken coinciding with a decode stall is ignored.
- stallCycles increments every cycle pc_en==0 with reset low. It wraps at 2^CNT_W.
- reset asserted mid-BUSY aborts the sequence. md_done is never pulsed.

Decomposition:
- Shared pipeline package holds:
  - 2-bit state encodings MD_IDLE=0, MD_BUSY=1, MD_DONE=2.
  - Default MULT_LAT/DIV_LAT.
  - Register-zero constant.
- One natural sub-module, md_seq: FSM plus md_cnt, with outputs md_start/md_busy/md_done.
- Hazard compare and priority logic stay in the top module.

Test Plan:
- Load to r5 in X, decode add uses r5: one cycle with pc_en=0, DX_flush=1; next cycle proceeds; stallCycles=1.
- Load to r0 in X, decode reads r0: no stall, all enables 1.
- Mult in X, MULT_LAT=4: md_start at t0; md_busy t0..t3; md_done t4; pc_en=0 t0..t3; XM_bubble=1 t0..t3; stallCycles=4.
- Div in X, DIV_LAT=8: md_done at t8. reset pulsed at t3: outputs zero immediately, IDLE after release, no md_done, stallCycles=0.
- X_branchTaken coincident with load-use match: FD_flush=DX_flush=1, pc_en=1, no stall.
- Decode beq using r7 with lw r7 in M: one-cycle stall. Next cycle D_branchTaken=1 gives FD_flush=1 only.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: multdiv
// occupancy state encodings, default latencies and the hard-wired zero
// register specifier.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 8;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_md_seq.sv
// Multdiv occupancy sequencer. Holds the front end frozen from the start
// cycle until the result is valid, then gives one DONE cycle in which a
// still-high mult/div decode cannot retrigger a start.
//
// Handshake: md_start is a single-cycle request pulse with no ready. The
// multdiv unit must accept it unconditionally. md_done is a single-cycle
// valid pulse, LAT cycles after md_start, with no back-pressure.
module pipe_hazard_ctrl_md_seq
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      start_req,
  input  logic      is_div,
  output logic      md_start,
  output logic      md_busy,
  output logic      md_done,
  output md_state_t md_state
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] md_cnt;

  // Start only from IDLE; DONE deliberately masks the still-present request.
  assign md_start = ~reset & (md_state == MD_IDLE) & start_req;
  assign md_busy  = md_start | (md_state == MD_BUSY);
  assign md_done  = (md_state == MD_DONE);

  // Occupancy FSM with latency down-counter; div wins if both flags are set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      case (md_state)
        MD_IDLE: begin
          if (start_req) begin
            md_cnt   <= is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
            md_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          md_cnt <= md_cnt - CW'(1);
          if (md_cnt == CW'(1)) md_state <= MD_DONE;
        end
        MD_DONE: begin
          md_state <= MD_IDLE;
        end
        default: begin
          md_state <= MD_IDLE;
          md_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller. Produces latch enables, flushes and
// bubbles for the hazards the bypass network cannot cover: load-use,
// decode-resolved branch/jr operands, taken-branch flushes and multdiv
// occupancy. Also counts cycles in which the PC is held.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       FD_rs,
  input  logic [4:0]       FD_rt,
  input  logic             FD_usesRs,
  input  logic             FD_usesRt,
  input  logic             FD_isCtrl,
  input  logic             D_branchTaken,
  input  logic [4:0]       DX_rd,
  input  logic             DX_regWrite,
  input  logic             DX_memRead,
  input  logic             DX_isMult,
  input  logic             DX_isDiv,
  input  logic [4:0]       XM_rd,
  input  logic             XM_memRead,
  input  logic             X_branchTaken,
  output logic             pc_en,
  output logic             FD_en,
  output logic             DX_en,
  output logic             FD_flush,
  output logic             DX_flush,
  output logic             XM_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stallCycles
);

  md_state_t md_state;
  logic      md_occ;
  logic      rs_dx, rt_dx, rs_xm, rt_xm;
  logic      load_use, ctrl_stall, dec_stall;

  pipe_hazard_ctrl_md_seq #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_seq (
    .clock     (clock),
    .reset     (reset),
    .start_req (DX_isMult | DX_isDiv),
    .is_div    (DX_isDiv),
    .md_start  (md_start),
    .md_busy   (md_busy),
    .md_done   (md_done),
    .md_state  (md_state)
  );

  // Front end is frozen on the start cycle and through BUSY, not in DONE.
  assign md_occ = md_start | (md_state == MD_BUSY);

  // Used-source matches against the X and M destinations.
  assign rs_dx = FD_usesRs & (FD_rs == DX_rd);
  assign rt_dx = FD_usesRt & (FD_rt == DX_rd);
  assign rs_xm = FD_usesRs & (FD_rs == XM_rd);
  assign rt_xm = FD_usesRt & (FD_rt == XM_rd);

  assign load_use   = DX_memRead & (DX_rd != REG_ZERO) & (rs_dx | rt_dx);
  assign ctrl_stall = FD_isCtrl &
                      (((DX_rd != REG_ZERO) & DX_regWrite & (rs_dx | rt_dx)) |
                       ((XM_rd != REG_ZERO) & XM_memRead  & (rs_xm | rt_xm)));
  assign dec_stall  = load_use | ctrl_stall;

  // Priority: reset, multdiv occupancy, X flush, decode stall, D flush.
  always_comb begin
    pc_en     = 1'b1;
    FD_en     = 1'b1;
    DX_en     = 1'b1;
    FD_flush  = 1'b0;
    DX_flush  = 1'b0;
    XM_bubble = 1'b0;
    if (reset) begin
      pc_en = 1'b0;
      FD_en = 1'b0;
      DX_en = 1'b0;
    end else if (md_occ) begin
      pc_en     = 1'b0;
      FD_en     = 1'b0;
      DX_en     = 1'b0;
      XM_bubble = 1'b1;
    end else if (X_branchTaken) begin
      FD_flush = 1'b1;
      DX_flush = 1'b1;
    end else if (dec_stall) begin
      pc_en    = 1'b0;
      FD_en    = 1'b0;
      DX_flush = 1'b1;
    end else if (D_branchTaken) begin
      FD_flush = 1'b1;
    end
  end

  // Count every out-of-reset cycle with the PC held; wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stallCycles <= '0;
    end else if (!pc_en) begin
      stallCycles <= stallCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle hazard
// vectors followed by hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  FD_rs, FD_rt, DX_rd, XM_rd;
  logic        FD_usesRs, FD_usesRt, FD_isCtrl, D_branchTaken;
  logic        DX_regWrite, DX_memRead, DX_isMult, DX_isDiv;
  logic        XM_memRead, X_branchTaken;
  logic        pc_en, FD_en, DX_en, FD_flush, DX_flush, XM_bubble;
  logic        md_start, md_busy, md_done;
  logic [31:0] stallCycles;

  int tests  = 0;
  int failed = 0;

  pipe_hazard_ctrl #(
    .MULT_LAT (4),
    .DIV_LAT  (8),
    .CNT_W    (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .FD_rs         (FD_rs),
    .FD_rt         (FD_rt),
    .FD_usesRs     (FD_usesRs),
    .FD_usesRt     (FD_usesRt),
    .FD_isCtrl     (FD_isCtrl),
    .D_branchTaken (D_branchTaken),
    .DX_rd         (DX_rd),
    .DX_regWrite   (DX_regWrite),
    .DX_memRead    (DX_memRead),
    .DX_isMult     (DX_isMult),
    .DX_isDiv      (DX_isDiv),
    .XM_rd         (XM_rd),
    .XM_memRead    (XM_memRead),
    .X_branchTaken (X_branchTaken),
    .pc_en         (pc_en),
    .FD_en         (FD_en),
    .DX_en         (DX_en),
    .FD_flush      (FD_flush),
    .DX_flush      (DX_flush),
    .XM_bubble     (XM_bubble),
    .md_start      (md_start),
    .md_busy       (md_busy),
    .md_done       (md_done),
    .stallCycles   (stallCycles)
  );

  // Clock and reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // A taken X branch must never coincide with multdiv occupancy.
  always @(posedge clock) begin
    if (!reset && md_busy && X_branchTaken) begin
      failed++;
      $display("FAIL xbt_during_md: X_branchTaken=1 while md_busy=1");
    end
  end

  // Output bundle: {pc_en,FD_en,DX_en,FD_flush,DX_flush,XM_bubble,md_start,md_busy,md_done}
  function automatic logic [8:0] outs();
    return {pc_en, FD_en, DX_en, FD_flush, DX_flush, XM_bubble, md_start, md_busy, md_done};
  endfunction

  localparam logic [5:0] P  = 6'b111000;  // proceed
  localparam logic [5:0] S  = 6'b001010;  // decode stall
  localparam logic [5:0] XF = 6'b111110;  // X-branch flush
  localparam logic [5:0] DF = 6'b111100;  // D-branch flush

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       urs, urt, ctrl, dbt;
    logic [4:0] dx_rd;
    logic       dx_rw, dx_mr;
    logic [4:0] xm_rd;
    logic       xm_mr, xbt;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic ctrl, input logic dbt,
                              input logic [4:0] dx_rd, input logic dx_rw, input logic dx_mr,
                              input logic [4:0] xm_rd, input logic xm_mr, input logic xbt,
                              input logic [5:0] exp);
    vec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.ctrl = ctrl; v.dbt = dbt;
    v.dx_rd = dx_rd; v.dx_rw = dx_rw; v.dx_mr = dx_mr; v.xm_rd = xm_rd; v.xm_mr = xm_mr;
    v.xbt = xbt; v.exp = exp;
    return v;
  endfunction

  // Driver tasks
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    FD_rs = 0; FD_rt = 0; FD_usesRs = 0; FD_usesRt = 0; FD_isCtrl = 0;
    D_branchTaken = 0; DX_rd = 0; DX_regWrite = 0; DX_memRead = 0;
    DX_isMult = 0; DX_isDiv = 0; XM_rd = 0; XM_memRead = 0; X_branchTaken = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    FD_rs = v.rs; FD_rt = v.rt; FD_usesRs = v.urs; FD_usesRt = v.urt;
    FD_isCtrl = v.ctrl; D_branchTaken = v.dbt;
    DX_rd = v.dx_rd; DX_regWrite = v.dx_rw; DX_memRead = v.dx_mr;
    XM_rd = v.xm_rd; XM_memRead = v.xm_mr; X_branchTaken = v.xbt;
    DX_isMult = 0; DX_isDiv = 0;
  endtask

  vec_t vecs[$];
  logic [31:0] exp_stall;

  initial begin
    reset = 1'b1;
    clear_inputs();
    #2;
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_stall", stallCycles, 32'd0);

    //           name             rs rt urs urt ctl dbt dxrd rw mr xmrd mr xbt exp
    vecs.push_back(mk("idle",           0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, P));
    vecs.push_back(mk("lu_rs",          5, 0, 1, 0, 0, 0,  5, 1, 1,  0, 0, 0, S));
    vecs.push_back(mk("lu_rt_unused",   3, 5, 1, 0, 0, 0,  5, 1, 1,  0, 0, 0, P));
    vecs.push_back(mk("lu_rt",          3, 5, 1, 1, 0, 0,  5, 1, 1,  0, 0, 0, S));
    vecs.push_back(mk("lu_r0",          0, 0, 1, 1, 0, 0,  0, 1, 1,  0, 0, 0, P));
    vecs.push_back(mk("alu_fwd",        7, 0, 1, 0, 0, 0,  7, 1, 0,  0, 0, 0, P));
    vecs.push_back(mk("ctrl_dx",        7, 0, 1, 0, 1, 0,  7, 1, 0,  0, 0, 0, S));
    vecs.push_back(mk("ctrl_dx_nowr",   7, 0, 1, 0, 1, 0,  7, 0, 0,  0, 0, 0, P));
    vecs.push_back(mk("ctrl_dx_r0",     0, 0, 1, 0, 1, 0,  0, 1, 0,  0, 0, 0, P));
    vecs.push_back(mk("ctrl_xm_load",   2, 9, 1, 1, 1, 0,  0, 0, 0,  9, 1, 0, S));
    vecs.push_back(mk("ctrl_xm_alu",    2, 9, 1, 1, 1, 0,  0, 0, 0,  9, 0, 0, P));
    vecs.push_back(mk("ctrl_xm_unused", 2, 9, 1, 0, 1, 0,  0, 0, 0,  9, 1, 0, P));
    vecs.push_back(mk("xm_load_noctrl", 2, 9, 1, 1, 0, 0,  0, 0, 0,  9, 1, 0, P));
    vecs.push_back(mk("xbt_over_lu",    5, 0, 1, 0, 0, 0,  5, 1, 1,  0, 0, 1, XF));
    vecs.push_back(mk("dbt",            1, 2, 1, 1, 1, 1,  3, 1, 0,  4, 1, 0, DF));
    vecs.push_back(mk("dbt_in_stall",   5, 0, 1, 0, 1, 1,  5, 1, 1,  0, 0, 0, S));
    vecs.push_back(mk("xbt_dbt",        1, 2, 1, 1, 1, 1,  0, 0, 0,  0, 0, 1, XF));

    // Table-driven single-cycle vectors, stall counter tracked alongside
    do_reset();
    exp_stall = 0;
    foreach (vecs[i]) begin
      @(negedge clock);
      apply(vecs[i]);
      #2;
      check(vecs[i].name, 32'(outs()), 32'({vecs[i].exp, 3'b000}));
      check({vecs[i].name, "_stallcnt"}, stallCycles, exp_stall);
      if (!vecs[i].exp[5]) exp_stall++;
    end

    // Load-use: one stall cycle, then proceed with load gone from X
    do_reset();
    @(negedge clock);
    FD_rs = 5; FD_usesRs = 1; DX_rd = 5; DX_regWrite = 1; DX_memRead = 1;
    #2 check("seq_lu_stall", 32'(outs()), 32'({S, 3'b000}));
    @(negedge clock);
    DX_rd = 0; DX_regWrite = 0; DX_memRead = 0;
    #2 check("seq_lu_go", 32'(outs()), 32'({P, 3'b000}));
    check("seq_lu_cnt", stallCycles, 32'd1);

    // beq on r7 with lw r7 in M, then taken in D
    do_reset();
    @(negedge clock);
    clear_inputs();
    FD_isCtrl = 1; FD_rs = 7; FD_usesRs = 1; XM_rd = 7; XM_memRead = 1;
    #2 check("seq_beq_stall", 32'(outs()), 32'({S, 3'b000}));
    @(negedge clock);
    XM_rd = 0; XM_memRead = 0; D_branchTaken = 1;
    #2 check("seq_beq_taken", 32'(outs()), 32'({DF, 3'b000}));

    // Mult, latency 4: freeze t0..t3, done at t4
    do_reset();
    @(negedge clock);
    clear_inputs();
    DX_isMult = 1; DX_rd = 3; DX_regWrite = 1;
    for (int t = 0; t <= 4; t++) begin
      if (t > 0) @(negedge clock);
      #2;
      if (t < 4) check($sformatf("mult_t%0d", t), 32'(outs()), 32'({6'b000001, (t == 0), 1'b1, 1'b0}));
      else       check("mult_t4", 32'(outs()), 32'({P, 3'b001}));
    end
    @(negedge clock);
    clear_inputs();
    #2 check("mult_after", 32'(outs()), 32'({P, 3'b000}));
    check("mult_cnt", stallCycles, 32'd4);

    // Div with both flags set: div latency applies, done at t8
    begin
      int done_at;
      done_at = -1;
      do_reset();
      @(negedge clock);
      DX_isDiv = 1; DX_isMult = 1;
      for (int t = 0; t < 20 && done_at < 0; t++) begin
        if (t > 0) @(negedge clock);
        #2;
        if (md_done) done_at = t;
      end
      check("div_done_cycle", 32'(done_at), 32'd8);
      @(negedge clock);
      clear_inputs();
      #2 check("div_cnt", stallCycles, 32'd8);
    end

    // Div aborted by reset at t3
    begin
      int dones;
      dones = 0;
      do_reset();
      @(negedge clock);
      DX_isDiv = 1;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      DX_isDiv = 0;
      #1 check("abort_outs", 32'(outs()), 32'd0);
      check("abort_cnt_rst", stallCycles, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #2 check("abort_idle", 32'(outs()), 32'({P, 3'b000}));
      for (int t = 0; t < 12; t++) begin
        @(negedge clock);
        #2;
        if (md_done || md_busy) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      check("abort_cnt", stallCycles, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
